// File: rtl/breakout_tick_pkg.sv
// Shared types and constants for the breakout game tick master and its bus port.
// States, timer word addresses and control-register bit positions live here.
package breakout_tick_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PERL,
        ST_WR_PERH,
        ST_WR_CTRL,
        ST_RUN,
        ST_WR_STAT,
        ST_SETTLE,
        ST_WR_STOP,
        ST_WR_SNAP,
        ST_RD_SL,
        ST_RD_SH,
        ST_CAP
    } tick_state_t;

    localparam logic [2:0] TMR_STATUS = 3'd0;
    localparam logic [2:0] TMR_CTRL   = 3'd1;
    localparam logic [2:0] TMR_PERL   = 3'd2;
    localparam logic [2:0] TMR_PERH   = 3'd3;
    localparam logic [2:0] TMR_SNAPL  = 3'd4;
    localparam logic [2:0] TMR_SNAPH  = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_RUN_WORD  = 16'((1 << CTRL_START) | (1 << CTRL_CONT) | (1 << CTRL_ITO));
    localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_req_t;

endpackage

// File: rtl/breakout_av_wr_port.sv
// Registers the FSM bus request onto the Avalon-MM master pins; one cycle per access.
// Idle bus drives zeros with write_n high so the slave sees a clean, quiet interface.
module breakout_av_wr_port
    import breakout_tick_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  bus_req_t    req,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            av_address    <= '0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= '0;
        end else begin
            av_chipselect <= req.cs;
            av_write_n    <= req.cs ? req.wr_n : 1'b1;
            av_address    <= req.cs ? req.addr : '0;
            av_writedata  <= req.cs ? req.data : '0;
        end
    end

endmodule

// File: rtl/breakout_tick_master.sv
// Avalon-MM master that programs the game interval timer and turns each serviced timeout into game_tick_o.
// Optional live-counter capture is built when SNAPSHOT_READ_EN is defined.
//
// state      | meaning
// IDLE       | timer stopped, period changes only latched
// WR_PERL    | write period low half
// WR_PERH    | write period high half
// WR_CTRL    | start timer, continuous with irq
// RUN        | waiting for irq / disable / period change / snapshot
// WR_STAT    | clear timeout status
// SETTLE     | bus idle while irq drops; game_tick_o high
// WR_STOP    | stop timer, then IDLE
// WR_SNAP    | latch live counter in the slave
// RD_SL      | read snapshot low
// RD_SH      | read snapshot high, capture low
// CAP        | capture high, publish snapshot
module breakout_tick_master
    import breakout_tick_pkg::*;
#(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49999,
    parameter int          TICK_CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [31:0]           period_i,
    input  logic                  period_valid_i,
    output logic                  period_ready_o,
    output logic                  game_tick_o,
    output logic [TICK_CNT_W-1:0] tick_count_o,
    output logic                  busy_o,
    output logic [2:0]            av_address,
    output logic                  av_chipselect,
    output logic                  av_write_n,
    output logic [15:0]           av_writedata,
    input  logic [15:0]           av_readdata,
    input  logic                  av_irq
`ifdef SNAPSHOT_READ_EN
    ,
    input  logic                  snap_req_i,
    output logic [31:0]           snap_value_o,
    output logic                  snap_valid_o
`endif
);

    tick_state_t state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        ready;
    logic        accept;
    bus_req_t    req;

    assign ready          = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !av_irq && enable_i);
    assign period_ready_o = ready & ~reset;
    assign accept         = period_valid_i & ready;
    // Forward the accepted period so WR_PERL, entered on the same edge, writes the new value.
    assign period_d       = accept ? period_i : period_q;
    assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable_i) state_d = ST_WR_PERL;
            ST_WR_PERL: state_d = ST_WR_PERH;
            ST_WR_PERH: state_d = ST_WR_CTRL;
            ST_WR_CTRL: state_d = enable_i ? ST_RUN : ST_WR_STOP;
            ST_RUN: begin
                if (av_irq)        state_d = ST_WR_STAT;
                else if (!enable_i) state_d = ST_WR_STOP;
                else if (accept)    state_d = ST_WR_PERL;
`ifdef SNAPSHOT_READ_EN
                else if (snap_req_i) state_d = ST_WR_SNAP;
`endif
            end
            ST_WR_STAT: state_d = ST_SETTLE;
            ST_SETTLE:  state_d = ST_RUN;
            ST_WR_STOP: state_d = ST_IDLE;
`ifdef SNAPSHOT_READ_EN
            ST_WR_SNAP: state_d = ST_RD_SL;
            ST_RD_SL:   state_d = ST_RD_SH;
            ST_RD_SH:   state_d = ST_CAP;
            ST_CAP:     state_d = ST_RUN;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus request is decoded from the next state so the registered pins line up with the state itself.
    always_comb begin
        req.cs   = 1'b0;
        req.wr_n = 1'b1;
        req.addr = TMR_STATUS;
        req.data = 16'h0000;
        case (state_d)
            ST_WR_PERL: begin
                req.cs = 1'b1; req.wr_n = 1'b0; req.addr = TMR_PERL; req.data = period_d[15:0];
            end
            ST_WR_PERH: begin
                req.cs = 1'b1; req.wr_n = 1'b0; req.addr = TMR_PERH; req.data = period_d[31:16];
            end
            ST_WR_CTRL: begin
                req.cs = 1'b1; req.wr_n = 1'b0; req.addr = TMR_CTRL; req.data = CTRL_RUN_WORD;
            end
            ST_WR_STAT: begin
                req.cs = 1'b1; req.wr_n = 1'b0; req.addr = TMR_STATUS;
            end
            ST_WR_STOP: begin
                req.cs = 1'b1; req.wr_n = 1'b0; req.addr = TMR_CTRL; req.data = CTRL_STOP_WORD;
            end
`ifdef SNAPSHOT_READ_EN
            ST_WR_SNAP: begin
                req.cs = 1'b1; req.wr_n = 1'b0; req.addr = TMR_SNAPL;
            end
            ST_RD_SL: begin
                req.cs = 1'b1; req.addr = TMR_SNAPL;
            end
            ST_RD_SH: begin
                req.cs = 1'b1; req.addr = TMR_SNAPH;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            period_q     <= PERIOD_DEFAULT;
            game_tick_o  <= 1'b0;
            tick_count_o <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            game_tick_o <= (state_d == ST_SETTLE);
            if (state_d == ST_SETTLE)
                tick_count_o <= tick_count_o + TICK_CNT_W'(1);
        end
    end

`ifdef SNAPSHOT_READ_EN
    logic [15:0] snap_lo_q;

    // Read data lags its read cycle by one, so RD_SH sees the low half and CAP sees the high half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_lo_q    <= '0;
            snap_value_o <= '0;
            snap_valid_o <= 1'b0;
        end else begin
            snap_valid_o <= 1'b0;
            if (state_q == ST_RD_SH)
                snap_lo_q <= av_readdata;
            if (state_q == ST_CAP) begin
                snap_value_o <= {av_readdata, snap_lo_q};
                snap_valid_o <= 1'b1;
            end
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^av_readdata;
`endif

    breakout_av_wr_port u_port (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata)
    );

endmodule

// File: tb/tb_breakout_tick_master.sv
// Bench for breakout_tick_master with a behavioural interval-timer slave on the same clk/reset.
// Bus writes are checked against a queue of expected {address, data} records.
`timescale 1ns/1ps
module tb_breakout_tick_master;
    import breakout_tick_pkg::*;

    localparam int CNT_W = 4;

    logic             clk, reset, enable_i, period_valid_i, period_ready_o;
    logic             game_tick_o, busy_o;
    logic [31:0]      period_i;
    logic [CNT_W-1:0] tick_count_o;
    logic [2:0]       av_address;
    logic             av_chipselect, av_write_n, av_irq;
    logic [15:0]      av_writedata, av_readdata;
`ifdef SNAPSHOT_READ_EN
    logic             snap_req_i, snap_valid_o;
    logic [31:0]      snap_value_o;
`endif

    breakout_tick_master #(.PERIOD_DEFAULT(32'd49999), .TICK_CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .period_i(period_i),
        .period_valid_i(period_valid_i), .period_ready_o(period_ready_o),
        .game_tick_o(game_tick_o), .tick_count_o(tick_count_o), .busy_o(busy_o),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata), .av_irq(av_irq)
`ifdef SNAPSHOT_READ_EN
        , .snap_req_i(snap_req_i), .snap_value_o(snap_value_o), .snap_valid_o(snap_valid_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Interval timer slave: irq is registered, so it drops one cycle after the status write.
    logic [31:0] tmr_period, tmr_count, tmr_snap;
    logic        tmr_run, tmr_cont, tmr_ito, tmr_to;
    logic [15:0] tmr_rdata;
    assign av_readdata = tmr_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_period <= '0; tmr_count <= '0; tmr_snap <= '0; tmr_rdata <= '0;
            tmr_run <= 1'b0; tmr_cont <= 1'b0; tmr_ito <= 1'b0; tmr_to <= 1'b0; av_irq <= 1'b0;
        end else begin
            av_irq <= tmr_to & tmr_ito;
            if (tmr_run) begin
                if (tmr_count == 0) begin
                    tmr_to <= 1'b1;
                    tmr_count <= tmr_period;
                    if (!tmr_cont) tmr_run <= 1'b0;
                end else begin
                    tmr_count <= tmr_count - 1;
                end
            end
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    TMR_STATUS: if (!(tmr_run && tmr_count == 0)) tmr_to <= 1'b0;
                    TMR_CTRL: begin
                        tmr_ito  <= av_writedata[0];
                        tmr_cont <= av_writedata[1];
                        if (av_writedata[2]) tmr_run <= 1'b1;
                        if (av_writedata[3]) tmr_run <= 1'b0;
                    end
                    TMR_PERL: begin
                        tmr_period[15:0] <= av_writedata;
                        tmr_count <= {tmr_period[31:16], av_writedata};
                        tmr_run <= 1'b0;
                    end
                    TMR_PERH: begin
                        tmr_period[31:16] <= av_writedata;
                        tmr_count <= {av_writedata, tmr_period[15:0]};
                        tmr_run <= 1'b0;
                    end
                    TMR_SNAPL, TMR_SNAPH: tmr_snap <= tmr_count;
                    default: ;
                endcase
            end
            if (av_chipselect && av_write_n) begin
                case (av_address)
                    TMR_STATUS: tmr_rdata <= {15'd0, tmr_to};
                    TMR_SNAPL:  tmr_rdata <= tmr_snap[15:0];
                    TMR_SNAPH:  tmr_rdata <= tmr_snap[31:16];
                    default:    tmr_rdata <= '0;
                endcase
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_exp_t;
    bus_exp_t sb[$];

    task automatic push_exp(input logic [2:0] a, input logic [15:0] d);
        bus_exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_period(input logic [31:0] p);
        push_exp(TMR_PERL, p[15:0]);
        push_exp(TMR_PERH, p[31:16]);
        push_exp(TMR_CTRL, 16'h0007);
    endtask

    // Monitor: scoreboard pops, tick count model, double-pulse detection.
    int   ticks = 0, stat_writes = 0, last_tick_cyc = 0, last_gap = 0, ctrl_cyc = 0;
    int   exp_cnt = 0;
    logic tick_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_cnt = 0;
            tick_prev = 1'b0;
        end else begin
            if (av_chipselect && !av_write_n) begin
                if (av_address == TMR_STATUS) begin
                    stat_writes++;
                    check("status_wdata", {16'd0, av_writedata}, 32'd0);
                end else if (av_address inside {TMR_CTRL, TMR_PERL, TMR_PERH}) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %h, none expected (cycle %0d)",
                                 av_address, av_writedata, cyc);
                    end else begin
                        bus_exp_t e;
                        e = sb.pop_front();
                        check("bus_write", {13'd0, av_address, av_writedata}, {13'd0, e.addr, e.data});
                    end
                    if (av_address == TMR_CTRL && av_writedata == 16'h0007) ctrl_cyc = cyc;
                end
            end
            if (game_tick_o) begin
                if (tick_prev) begin
                    checks++;
                    errors++;
                    $display("FAIL double_tick: game_tick_o high two cycles (cycle %0d)", cyc);
                end
                ticks++;
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                last_gap = cyc - last_tick_cyc;
                last_tick_cyc = cyc;
                check("tick_count", {28'd0, tick_count_o}, exp_cnt);
            end
            tick_prev = game_tick_o;
        end
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n, input int budget, input string name);
        int start = ticks;
        int t = 0;
        while ((ticks - start) < n && t < budget) begin
            nstep();
            t++;
        end
        if ((ticks - start) < n) fail_now(name);
    endtask

    task automatic wait_sb_empty(input int budget, input string name);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            nstep();
            t++;
        end
        if (sb.size() != 0) fail_now(name);
        nstep();
    endtask

    task automatic change_period(input logic [31:0] p, input bit in_run);
        int t = 0;
        nstep();
        if (in_run) push_period(p);
        period_i = p;
        period_valid_i = 1'b1;
        while (!period_ready_o && t < 200) begin
            nstep();
            t++;
        end
        if (!period_ready_o) fail_now("period_handshake");
        nstep();
        period_valid_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0] period;
        int          exp_gap;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int t;
        int idle_ticks;
        int dt;

        tbl[0] = '{period: 32'd9,          exp_gap: 10};
        tbl[1] = '{period: 32'd25,         exp_gap: 26};
        tbl[2] = '{period: 32'h0003_0004,  exp_gap: 0};
        tbl[3] = '{period: 32'd14,         exp_gap: 15};

        reset = 1'b1; enable_i = 1'b0; period_i = '0; period_valid_i = 1'b0;
`ifdef SNAPSHOT_READ_EN
        snap_req_i = 1'b0;
`endif
        #23;
        check("rst_chipselect", {31'd0, av_chipselect}, 32'd0);
        check("rst_write_n",    {31'd0, av_write_n},    32'd1);
        check("rst_address",    {29'd0, av_address},    32'd0);
        check("rst_writedata",  {16'd0, av_writedata},  32'd0);
        check("rst_tick",       {31'd0, game_tick_o},   32'd0);
        check("rst_count",      {28'd0, tick_count_o},  32'd0);
        check("rst_busy",       {31'd0, busy_o},        32'd0);
        check("rst_ready",      {31'd0, period_ready_o}, 32'd0);
        nstep();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) nstep();
        check("idle_ready", {31'd0, period_ready_o}, 32'd1);
        check("idle_quiet_bus", {31'd0, av_chipselect}, 32'd0);

        // Default period programming and first timeout.
        push_period(32'd49999);
        enable_i = 1'b1;
        nstep();
        check("seq_busy", {31'd0, busy_o}, 32'd1);
        wait_sb_empty(20, "default_writes");
        wait_ticks(1, 50100, "first_tick");
        dt = last_tick_cyc - ctrl_cyc;
        checks++;
        if (dt < 50002 || dt > 50006) begin
            errors++;
            $display("FAIL first_tick_delay: got %0d cycles expected 50002..50006", dt);
        end

        // Period changes in RUN from the table.
        foreach (tbl[i]) begin
            change_period(tbl[i].period, 1'b1);
            wait_sb_empty(40, "period_writes");
            if (tbl[i].exp_gap != 0) begin
                wait_ticks(3, 4 * tbl[i].exp_gap + 20, "table_ticks");
                check("tick_gap", last_gap, tbl[i].exp_gap);
            end
        end

        // 100 ticks at period 9; counter wraps several times at CNT_W bits.
        change_period(32'd9, 1'b1);
        wait_sb_empty(40, "p9_writes");
        wait_ticks(2, 60, "p9_settle");
        for (int i = 0; i < 100; i++) begin
            wait_ticks(1, 30, "p9_tick");
            check("p9_gap", last_gap, 10);
        end

        // Disable while WR_PERH is on the bus: sequence completes, then stop.
        nstep();
        push_period(32'd9);
        push_exp(TMR_CTRL, 16'h0008);
        period_i = 32'd9;
        period_valid_i = 1'b1;
        t = 0;
        while (!(av_chipselect && !av_write_n && av_address == TMR_PERH) && t < 300) begin
            nstep();
            t++;
        end
        if (t >= 300) fail_now("find_wr_perh");
        enable_i = 1'b0;
        period_valid_i = 1'b0;
        wait_sb_empty(20, "stop_writes");
        check("stop_busy", {31'd0, busy_o}, 32'd0);
        check("stop_ready", {31'd0, period_ready_o}, 32'd1);
        idle_ticks = ticks;
        for (int i = 0; i < 100; i++) nstep();
        check("stopped_ticks", ticks, idle_ticks);
        check("stopped_irq", {31'd0, av_irq}, 32'd0);

        // Latch in IDLE, then reset in the middle of WR_PERL.
        change_period(32'd9, 1'b0);
        check("idle_latch_busy", {31'd0, busy_o}, 32'd0);
        push_exp(TMR_PERL, 16'h0009);
        enable_i = 1'b1;
        t = 0;
        while (!(av_chipselect && av_address == TMR_PERL) && t < 20) begin
            nstep();
            t++;
        end
        if (t >= 20) fail_now("find_wr_perl");
        reset = 1'b1;
        #1;
        check("mid_rst_cs",    {31'd0, av_chipselect},  32'd0);
        check("mid_rst_wr_n",  {31'd0, av_write_n},     32'd1);
        check("mid_rst_busy",  {31'd0, busy_o},         32'd0);
        check("mid_rst_count", {28'd0, tick_count_o},   32'd0);
        check("mid_rst_ready", {31'd0, period_ready_o}, 32'd0);
        sb.delete();
        nstep();
        nstep();
        push_period(32'd49999);
        reset = 1'b0;
        wait_sb_empty(20, "restart_writes");
        check("restart_run", {31'd0, busy_o}, 32'd0);
        push_exp(TMR_CTRL, 16'h0008);
        enable_i = 1'b0;
        wait_sb_empty(20, "restart_stop");

`ifdef SNAPSHOT_READ_EN
        change_period(32'd1000, 1'b0);
        push_period(32'd1000);
        enable_i = 1'b1;
        wait_sb_empty(20, "snap_setup");
        wait_ticks(1, 1100, "snap_first_tick");
        for (int i = 0; i < 100; i++) nstep();
        snap_req_i = 1'b1;
        nstep();
        snap_req_i = 1'b0;
        t = 0;
        while (!snap_valid_o && t < 20) begin
            nstep();
            t++;
        end
        if (!snap_valid_o) fail_now("snap_valid");
        check("snap_value", snap_value_o, tmr_snap);
        checks++;
        if (tmr_snap > 32'd1000) begin
            errors++;
            $display("FAIL snap_range: got %0d expected <= 1000", tmr_snap);
        end
        nstep();
        check("snap_pulse", {31'd0, snap_valid_o}, 32'd0);
        push_exp(TMR_CTRL, 16'h0008);
        enable_i = 1'b0;
        wait_sb_empty(2000, "snap_stop");
`endif

        for (int i = 0; i < 10; i++) nstep();
        check("stat_per_tick", stat_writes, ticks);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
